// File: rtl/regfile_param_if.sv
// Bundle of decode/writeback-facing signals for regfile_param.
// The register file is the slave; the pipeline (or a bench) is the master.
interface regfile_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] write_reg;
    logic              write_en;
    logic [ADDR_W-1:0] read_reg1;
    logic              read_en1;
    logic [ADDR_W-1:0] read_reg2;
    logic              read_en2;
    logic [DATA_W-1:0] read_data1_o;
    logic [DATA_W-1:0] read_data2_o;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data_o;
    logic              ready;

    modport master (
        output write_data, write_reg, write_en,
        output read_reg1, read_en1, read_reg2, read_en2,
        output dbg_addr,
        input  read_data1_o, read_data2_o, dbg_data_o, ready
    );

    modport slave (
        input  write_data, write_reg, write_en,
        input  read_reg1, read_en1, read_reg2, read_en2,
        input  dbg_addr,
        output read_data1_o, read_data2_o, dbg_data_o, ready
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with registered reads, write bypass,
// optional hardwired zero entry and a post-reset clearing sweep.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [0:0]        state_reg;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_fire;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [ADDR_W-1:0] rd_addr [2];
    logic              rd_en   [2];
    logic [DATA_W-1:0] rd_data [2];

    // A write counts only in RUN and only if it is not aimed at the hardwired zero.
    always_comb begin
        wr_fire = (state_reg == RUN) && bus.write_en &&
                  !((ZERO_REG != 0) && (bus.write_reg == '0));
    end

    // The sweep and normal writes share the single storage write port.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.write_reg;
        mem_wdata = bus.write_data;
        if (!rst) begin
            if (state_reg == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_reg;
                mem_wdata = '0;
            end else if (wr_fire) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
        end else if (state_reg == CLEAR) begin
            clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
            if (clr_cnt_reg == LAST_ADDR) begin
                state_reg <= RUN;
            end
        end
    end

    assign rd_addr[0] = bus.read_reg1;
    assign rd_addr[1] = bus.read_reg2;
    assign rd_en[0]   = bus.read_en1;
    assign rd_en[1]   = bus.read_en2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] data_next;
            logic [DATA_W-1:0] data_reg;

            // Zero entry wins over bypass; bypass wins over stored contents.
            always_comb begin
                if ((ZERO_REG != 0) && (rd_addr[gi] == '0)) begin
                    data_next = '0;
                end else if (wr_fire && (bus.write_reg == rd_addr[gi])) begin
                    data_next = bus.write_data;
                end else begin
                    data_next = mem[rd_addr[gi]];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= '0;
                end else if ((state_reg == RUN) && rd_en[gi]) begin
                    data_reg <= data_next;
                end
            end

            assign rd_data[gi] = data_reg;
        end
    endgenerate

    assign bus.read_data1_o = rd_data[0];
    assign bus.read_data2_o = rd_data[1];
    assign bus.ready        = (state_reg == RUN);
    assign bus.dbg_data_o   = ((ZERO_REG != 0) && (bus.dbg_addr == '0)) ? '0 : mem[bus.dbg_addr];
endmodule
